// File: rtl/param_sender_pkg.sv
// Shared definitions for the serial sender (and its matching receiver).
//   - Parity mode constants used by the PARITY parameter.
//   - FSM state encoding for the transmit frame sequencer.
//   - parity_bit(): final parity bit from the running XOR of the data bits.
package param_sender_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    // acc is the XOR of all data bits; even parity sends it as-is, odd inverts it.
    function automatic logic parity_bit(input logic acc, input int unsigned mode);
        if (mode == PAR_ODD) begin
            return ~acc;
        end else if (mode == PAR_EVEN) begin
            return acc;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/param_sender_if.sv
// Producer-side bus of the serial sender.
//   tx_data     word to send, sampled while tx_en is high
//   tx_en       write strobe, one word per high cycle
//   tx_full     FIFO full, writes are dropped
//   tx_overflow one-cycle pulse after a dropped write
//   tx_status   1 = FIFO empty and line idle
//   dout        serial line, idles high
// master: the byte producer; slave: the sender.
interface param_sender_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_en;
    logic                  tx_full;
    logic                  tx_overflow;
    logic                  tx_status;
    logic                  dout;

    modport master (
        output tx_data,
        output tx_en,
        input  tx_full,
        input  tx_overflow,
        input  tx_status,
        input  dout
    );

    modport slave (
        input  tx_data,
        input  tx_en,
        output tx_full,
        output tx_overflow,
        output tx_status,
        output dout
    );
endinterface

// File: rtl/param_sender_sync_fifo.sv
// Synchronous FIFO holding words waiting to be serialised.
//   clk, rst   system clock, synchronous active-high reset (flushes contents)
//   push/wdata write a word; ignored while full
//   pop/rdata  rdata is the head word; pop discards it; ignored while empty
//   full/empty flags derived from the registered count
//   count      registered number of stored words
module param_sender_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/param_sender.sv
// Parametrised asynchronous serial transmitter with TX FIFO.
//   clk  system clock; bit timing is derived from it by an internal divider
//   rst  synchronous active-high reset; aborts any frame in flight
//   bus  slave side of param_sender_if (tx_data/tx_en in; tx_full, tx_overflow,
//        tx_status and the registered serial line dout out)
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop(1),
// every bit held CLK_DIV cycles. Queued words follow each other with no idle gap.
module param_sender
    import param_sender_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 5,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    param_sender_if.slave bus
);
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS);

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  dout_q, dout_d;
    logic                  status_q, status_d;
    logic                  ovf_q;

    logic                  fifo_pop, fifo_full, fifo_empty, push_ok, baud_end;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count, count_next;

    param_sender_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.tx_en),
        .pop   (fifo_pop),
        .wdata (bus.tx_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign push_ok    = bus.tx_en && !fifo_full;
    // The FSM only pops when the FIFO is non-empty, so this is the FIFO's next count.
    assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);
    assign baud_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        dout_d   = dout_q;
        fifo_pop = 1'b0;

        if (state_q != StIdle) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    par_d    = 1'b0;
                    dout_d   = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    dout_d  = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = BIT_W'(1);
                    state_d = StData;
                end
            end
            StData: begin
                // bit_q counts data bits already placed on the line.
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = BIT_W'(1);
                        if (PARITY != PAR_NONE) begin
                            dout_d  = parity_bit(par_q, PARITY);
                            state_d = StPar;
                        end else begin
                            dout_d  = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        dout_d  = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            StPar: begin
                if (baud_end) begin
                    dout_d  = 1'b1;
                    bit_d   = BIT_W'(1);
                    state_d = StStop;
                end
            end
            StStop: begin
                // bit_q reused to count stop bits.
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_head;
                            par_d    = 1'b0;
                            dout_d   = 1'b0;
                            state_d  = StStart;
                        end else begin
                            dout_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                dout_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        status_d = (state_d == StIdle) && (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            dout_q   <= 1'b1;
            status_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            dout_q   <= dout_d;
            status_q <= status_d;
            ovf_q    <= bus.tx_en && fifo_full;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.tx_status   = status_q;
    assign bus.tx_full     = fifo_full;
    assign bus.tx_overflow = ovf_q;

endmodule

// File: tb/tb_param_sender.sv
// Bench for param_sender: five instances cover the default, even/odd parity,
// two stop bits and a short-word/fast-divider configuration. Expected line
// levels are queued per clock when a word is written and popped every cycle.
module tb_param_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_sender_if #(.DATA_WIDTH(8)) if0 ();
    param_sender_if #(.DATA_WIDTH(8)) if1 ();
    param_sender_if #(.DATA_WIDTH(8)) if2 ();
    param_sender_if #(.DATA_WIDTH(8)) if3 ();
    param_sender_if #(.DATA_WIDTH(5)) if4 ();

    param_sender u_d0 (.clk(clk), .rst(rst), .bus(if0));
    param_sender #(.PARITY(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    param_sender #(.PARITY(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2));
    param_sender #(.STOP_BITS(2)) u_d3 (.clk(clk), .rst(rst), .bus(if3));
    param_sender #(.CLK_DIV(2), .DATA_WIDTH(5)) u_d4 (.clk(clk), .rst(rst), .bus(if4));

    logic [4:0] dout_v, status_v;
    assign dout_v   = {if4.dout, if3.dout, if2.dout, if1.dout, if0.dout};
    assign status_v = {if4.tx_status, if3.tx_status, if2.tx_status, if1.tx_status, if0.tx_status};

    int   n_checks = 0;
    int   n_err    = 0;
    logic exp_q[$];

    task automatic get_params(input int s, output int dw, output int div, output int par,
                              output int sb);
        dw = 8; div = 5; par = 0; sb = 1;
        case (s)
            1: par = 1;
            2: par = 2;
            3: sb = 2;
            4: begin dw = 5; div = 2; end
            default: ;
        endcase
    endtask

    task automatic set_in(input int s, input logic en, input logic [15:0] d);
        case (s)
            0: begin if0.tx_en = en; if0.tx_data = d[7:0]; end
            1: begin if1.tx_en = en; if1.tx_data = d[7:0]; end
            2: begin if2.tx_en = en; if2.tx_data = d[7:0]; end
            3: begin if3.tx_en = en; if3.tx_data = d[7:0]; end
            default: begin if4.tx_en = en; if4.tx_data = d[4:0]; end
        endcase
    endtask

    task automatic push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Scoreboard entry: one expected dout level per clock of the whole frame.
    task automatic push_frame(input int s, input logic [15:0] word, output int len);
        int   dw, div, par, sb;
        logic acc;
        get_params(s, dw, div, par, sb);
        acc = 1'b0;
        push_level(1'b0, div);
        for (int i = 0; i < dw; i++) begin
            acc = acc ^ word[i];
            push_level(word[i], div);
        end
        if (par != 0) push_level((par == 2) ? ~acc : acc, div);
        push_level(1'b1, sb * div);
        len = (1 + dw + ((par != 0) ? 1 : 0) + sb) * div;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance one clock, then compare dout with the scoreboard head (idle high when empty).
    task automatic tick_check(input int s, input string tag);
        logic e;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        chk_bit(tag, dout_v[s], e);
    endtask

    task automatic send_one(input int s, input logic [15:0] word, input string tag);
        int len, zeros;
        set_in(s, 1'b1, word);
        exp_q.push_back(1'b1);
        push_frame(s, word, len);
        tick_check(s, tag);
        zeros = (status_v[s] === 1'b0) ? 1 : 0;
        set_in(s, 1'b0, 16'h0);
        for (int i = 0; i < len; i++) begin
            tick_check(s, tag);
            if (status_v[s] === 1'b0) zeros++;
        end
        tick_check(s, tag);
        chk_bit({tag, "_status_back"}, status_v[s], 1'b1);
        chk_int({tag, "_status_low_cycles"}, zeros, len + 1);
    endtask

    initial begin
        logic [7:0] w4 [6];
        int         len;

        for (int s = 0; s < 5; s++) set_in(s, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        for (int s = 0; s < 5; s++) begin
            chk_bit("reset_dout", dout_v[s], 1'b1);
            chk_bit("reset_status", status_v[s], 1'b1);
        end
        chk_bit("reset_full", if0.tx_full, 1'b0);
        chk_bit("reset_overflow", if0.tx_overflow, 1'b0);

        // Default frame, 8'hC5
        send_one(0, 16'h00C5, "t1_default");
        // Even then odd parity, 8'h27
        send_one(1, 16'h0027, "t2_even");
        send_one(2, 16'h0027, "t2_odd");

        // Two stop bits, back-to-back words
        set_in(3, 1'b1, 16'h00C5);
        exp_q.push_back(1'b1);
        push_frame(3, 16'h00C5, len);
        tick_check(3, "t3_stop2");
        set_in(3, 1'b1, 16'h0027);
        push_frame(3, 16'h0027, len);
        tick_check(3, "t3_stop2");
        set_in(3, 1'b0, 16'h0);
        for (int i = 0; i < 2 * len - 1; i++) tick_check(3, "t3_stop2");
        tick_check(3, "t3_stop2");
        chk_bit("t3_status_back", status_v[3], 1'b1);

        // Six writes into a four-deep FIFO: the sixth is dropped
        for (int i = 0; i < 6; i++) w4[i] = 8'(8'h3A + 8'(i * 29));
        exp_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1'b1, {8'h00, w4[i]});
            if (i < 5) push_frame(0, {8'h00, w4[i]}, len);
            tick_check(0, "t4_fill");
            chk_bit($sformatf("t4_full_w%0d", i), if0.tx_full, (i >= 4));
            chk_bit($sformatf("t4_ovf_w%0d", i), if0.tx_overflow, (i == 5));
        end
        set_in(0, 1'b0, 16'h0);
        tick_check(0, "t4_fill");
        chk_bit("t4_ovf_drop", if0.tx_overflow, 1'b0);
        for (int i = 0; i < 5 * len + 20; i++) tick_check(0, "t4_frames");
        chk_bit("t4_status_back", status_v[0], 1'b1);
        chk_bit("t4_full_clear", if0.tx_full, 1'b0);

        // Reset during data bit 3 with two words queued
        exp_q.push_back(1'b1);
        push_frame(0, 16'h00A5, len);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'b1, 16'h00A5 + 16'(i));
            tick_check(0, "t5_pre");
        end
        set_in(0, 1'b0, 16'h0);
        for (int j = 3; j <= 22; j++) tick_check(0, "t5_pre");
        chk_bit("t5_busy_before_rst", status_v[0], 1'b0);
        rst = 1'b1;
        exp_q.delete();
        tick_check(0, "t5_rst_dout");
        chk_bit("t5_rst_status", status_v[0], 1'b1);
        chk_bit("t5_rst_full", if0.tx_full, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) tick_check(0, "t5_quiet");
        chk_bit("t5_status_quiet", status_v[0], 1'b1);

        // Short word, fast divider, 5'b10011
        send_one(4, 16'h0013, "t6_div2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
